oam_dma: RTL and testbench

CPU-side sprite DMA engine that fills the PPU's 256-byte OAM. A CPU write to the DMA page register halts the CPU, then the engine reads 256 bytes from CPU address space page `$XX00-$XXFF` and writes each byte into the PPU via its CPU-port register interface (OAMDATA, register 4). It sits directly upstream of `ppu`, sharing that module's `cpu_cs`/`cpu_rw`/`cpu_addr`/`cpu_data_i` port through the CPU-side bus mux. One `clk` equals one CPU cycle.

---
 rtl/oam_dma.sv | 126 ++++++++++++
 tb/tb_oam_dma.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine that copies one 256-byte CPU page into PPU OAM.
//
// A CPU write of the page number to DMA_ADDR stalls the CPU. The engine then
// alternates GET (read a byte from memory) and PUT (write that byte to the
// PPU OAMDATA register) 256 times. GET cycles only fall on parity = 0, so the
// engine may insert one ALIGN cycle before the first GET.
//
// Ports:
//   clk, rst          one CPU cycle per clock, asynchronous active-low reset
//   cpu_addr_i/_wr_i  CPU bus address and write strobe (trigger detection)
//   cpu_rw_i          CPU cycle type; the engine waits in HALT while it is 0
//   cpu_data_i        page number latched on trigger
//   cpu_halt_o        stalls the CPU while a transfer is in progress
//   mem_addr_o/_rd_o  DMA read request; data arrives on mem_data_i next cycle
//   ppu_cs_o/_rw_o    PPU register access strobe and direction (0 = write)
//   ppu_addr_o/data_o PPU register index and write data
//   busy_o            transfer in progress
module oam_dma #(
    parameter logic [15:0] DMA_ADDR    = 16'h4014,
    parameter logic [2:0]  OAMDATA_REG = 3'h4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_i,
    input  logic        cpu_wr_i,
    input  logic        cpu_rw_i,
    input  logic [7:0]  cpu_data_i,
    output logic        cpu_halt_o,
    output logic [15:0] mem_addr_o,
    output logic        mem_rd_o,
    input  logic [7:0]  mem_data_i,
    output logic        ppu_cs_o,
    output logic        ppu_rw_o,
    output logic [2:0]  ppu_addr_o,
    output logic [7:0]  ppu_data_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StGet,
        StPut
    } state_e;

    state_e      state_q, state_d;
    logic        parity_q;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            page_q   <= page_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_wr_i && (cpu_addr_i == DMA_ADDR)) begin
                    page_d  = cpu_data_i;
                    idx_d   = 8'h00;
                    state_d = StHalt;
                end
            end
            StHalt: begin
                // Next cycle's parity is ~parity_q; GET must land on parity 0.
                if (cpu_rw_i) begin
                    state_d = parity_q ? StGet : StAlign;
                end
            end
            StAlign: state_d = StGet;
            StGet:   state_d = StPut;
            StPut: begin
                if (idx_q == 8'hFF) begin
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StGet;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from registered state; only PUT passes mem_data_i through.
    always_comb begin
        cpu_halt_o = (state_q != StIdle);
        busy_o     = (state_q != StIdle);
        mem_rd_o   = 1'b0;
        mem_addr_o = 16'h0000;
        ppu_cs_o   = 1'b0;
        ppu_rw_o   = 1'b1;
        ppu_addr_o = 3'h0;
        ppu_data_o = 8'h00;
        unique case (state_q)
            StGet: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = {page_q, idx_q};
            end
            StPut: begin
                ppu_cs_o   = 1'b1;
                ppu_rw_o   = 1'b0;
                ppu_addr_o = OAMDATA_REG;
                ppu_data_o = mem_data_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed self-checking bench for oam_dma.
// A memory model returns byte (addr[7:0] ^ 8'h5A ^ (page - 2)) one cycle after
// each read, so page $02 holds i ^ 8'h5A. A negedge monitor logs every read
// address, PPU write and halted cycle; each scenario checks the log slice it
// produced against hand-computed values.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr_i = 16'h0000;
    logic        cpu_wr_i = 1'b0;
    logic        cpu_rw_i = 1'b1;
    logic [7:0]  cpu_data_i = 8'h00;
    logic        cpu_halt_o;
    logic [15:0] mem_addr_o;
    logic        mem_rd_o;
    logic [7:0]  mem_data_i = 8'h00;
    logic        ppu_cs_o;
    logic        ppu_rw_o;
    logic [2:0]  ppu_addr_o;
    logic [7:0]  ppu_data_o;
    logic        busy_o;

    oam_dma dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr_i (cpu_addr_i),
        .cpu_wr_i   (cpu_wr_i),
        .cpu_rw_i   (cpu_rw_i),
        .cpu_data_i (cpu_data_i),
        .cpu_halt_o (cpu_halt_o),
        .mem_addr_o (mem_addr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_data_i (mem_data_i),
        .ppu_cs_o   (ppu_cs_o),
        .ppu_rw_o   (ppu_rw_o),
        .ppu_addr_o (ppu_addr_o),
        .ppu_data_o (ppu_data_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
    endfunction

    // Reference cycle parity: 0 out of reset, toggles every clock.
    logic tb_par;
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_par <= 1'b0;
        else      tb_par <= ~tb_par;
    end

    // Memory model: registered read.
    always @(posedge clk) begin
        if (mem_rd_o) mem_data_i <= mem_byte(mem_addr_o);
    end

    // Bus monitor (sole writer of the logs).
    logic [15:0] rd_log[$];
    logic [7:0]  wr_log[$];
    int halt_cnt = 0;
    int bad_par  = 0;
    int bad_reg  = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (cpu_halt_o) halt_cnt++;
            if (mem_rd_o) begin
                rd_log.push_back(mem_addr_o);
                if (tb_par !== 1'b0) bad_par++;
            end
            if (ppu_cs_o) begin
                wr_log.push_back(ppu_data_o);
                if (ppu_addr_o !== 3'h4 || ppu_rw_o !== 1'b0) bad_reg++;
            end
        end
    end

    int rd_base, wr_base, halt_base;

    task automatic mark();
        rd_base   = rd_log.size();
        wr_base   = wr_log.size();
        halt_base = halt_cnt;
    endtask

    function automatic logic [31:0] outs();
        return {cpu_halt_o, busy_o, mem_rd_o, mem_addr_o,
                ppu_cs_o, ppu_rw_o, ppu_addr_o, ppu_data_o};
    endfunction

    // Assert a trigger in a cycle of the requested parity; returns at the
    // following negedge with cpu_rw_i still 0.
    task automatic start(input logic [7:0] page, input logic par);
        @(negedge clk);
        while (tb_par !== par) @(negedge clk);
        cpu_addr_i = 16'h4014;
        cpu_data_i = page;
        cpu_wr_i   = 1'b1;
        cpu_rw_i   = 1'b0;
        @(negedge clk);
        cpu_wr_i   = 1'b0;
        cpu_addr_i = 16'h0000;
        check_eq("halt_rise", {30'd0, cpu_halt_o, busy_o}, 32'd3);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (busy_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, busy_o, 1'b0);
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] page);
        int de = 0;
        int ae = 0;
        for (int i = 0; i < 256; i++) begin
            logic [15:0] a;
            a = {page, 8'(i)};
            if (rd_base + i < rd_log.size()) begin
                if (rd_log[rd_base + i] !== a) ae++;
            end
            if (wr_base + i < wr_log.size()) begin
                if (wr_log[wr_base + i] !== mem_byte(a)) de++;
            end
        end
        check_eq({tag, "_rd_cnt"}, rd_log.size() - rd_base, 256);
        check_eq({tag, "_wr_cnt"}, wr_log.size() - wr_base, 256);
        check_eq({tag, "_addr_errs"}, ae, 0);
        check_eq({tag, "_data_errs"}, de, 0);
        check_eq({tag, "_get_parity"}, bad_par, 0);
        check_eq({tag, "_ppu_reg"}, bad_reg, 0);
    endtask

    initial begin
        int n;
        #12;
        check_eq("reset_outs", outs(), 32'h0000_0800);
        @(negedge clk);
        rst = 1'b1;

        // Page $02, even-parity trigger: 513 halted cycles.
        mark();
        start(8'h02, 1'b0);
        cpu_rw_i = 1'b1;
        wait_done("t1_done");
        check_xfer("t1", 8'h02);
        check_eq("t1_halt", halt_cnt - halt_base, 513);
        check_eq("t1_first_data", wr_log[wr_base], 8'h5A);
        check_eq("t1_second_data", wr_log[wr_base + 1], 8'h5B);
        check_eq("t1_last_data", wr_log[wr_base + 255], 8'hA5);
        check_eq("t1_first_addr", rd_log[rd_base], 16'h0200);
        check_eq("t1_last_addr", rd_log[rd_base + 255], 16'h02FF);

        // Odd-parity trigger: ALIGN inserted, 514 halted cycles.
        mark();
        start(8'h05, 1'b1);
        cpu_rw_i = 1'b1;
        wait_done("t2_done");
        check_xfer("t2", 8'h05);
        check_eq("t2_halt", halt_cnt - halt_base, 514);

        // CPU keeps writing for 3 more cycles: 4 HALT cycles, then ALIGN.
        mark();
        start(8'h04, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("t3_no_rd_in_halt", rd_log.size() - rd_base, 0);
        check_eq("t3_still_halt", cpu_halt_o, 1'b1);
        cpu_rw_i = 1'b1;
        wait_done("t3_done");
        check_xfer("t3", 8'h04);
        check_eq("t3_halt", halt_cnt - halt_base, 517);

        // Retrigger mid-transfer is ignored; back-to-back trigger on first IDLE.
        mark();
        start(8'h03, 1'b0);
        cpu_rw_i = 1'b1;
        n = 0;
        while ((rd_log.size() - rd_base) < 50 && n < 400) begin
            @(negedge clk);
            n++;
        end
        cpu_addr_i = 16'h4014;
        cpu_data_i = 8'h07;
        cpu_wr_i   = 1'b1;
        cpu_rw_i   = 1'b0;
        @(negedge clk);
        cpu_wr_i   = 1'b0;
        cpu_addr_i = 16'h0000;
        cpu_rw_i   = 1'b1;
        wait_done("t4_done");
        check_xfer("t4", 8'h03);
        mark();
        cpu_addr_i = 16'h4014;
        cpu_data_i = 8'h06;
        cpu_wr_i   = 1'b1;
        cpu_rw_i   = 1'b0;
        @(negedge clk);
        cpu_wr_i   = 1'b0;
        cpu_addr_i = 16'h0000;
        cpu_rw_i   = 1'b1;
        check_eq("t5_b2b_halt", cpu_halt_o, 1'b1);
        wait_done("t5_done");
        check_xfer("t5", 8'h06);

        // Reset during byte 100 aborts at once; no activity afterwards.
        mark();
        start(8'h08, 1'b0);
        cpu_rw_i = 1'b1;
        n = 0;
        while ((rd_log.size() - rd_base) <= 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_reached_byte100", (rd_log.size() - rd_base) > 100, 1'b1);
        #2 rst = 1'b0;
        #1 check_eq("t6_reset_outs", outs(), 32'h0000_0800);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mark();
        repeat (20) @(negedge clk);
        check_eq("t6_quiet_rd", rd_log.size() - rd_base, 0);
        check_eq("t6_quiet_wr", wr_log.size() - wr_base, 0);
        check_eq("t6_quiet_halt", halt_cnt - halt_base, 0);

        // Neighbouring addresses and a read of $4014 do not trigger.
        mark();
        @(negedge clk);
        cpu_addr_i = 16'h4013;
        cpu_data_i = 8'h09;
        cpu_wr_i   = 1'b1;
        cpu_rw_i   = 1'b0;
        @(negedge clk);
        cpu_addr_i = 16'h4015;
        @(negedge clk);
        cpu_addr_i = 16'h4014;
        cpu_wr_i   = 1'b0;
        cpu_rw_i   = 1'b1;
        @(negedge clk);
        cpu_addr_i = 16'h0000;
        repeat (10) @(negedge clk);
        check_eq("t7_no_halt", halt_cnt - halt_base, 0);
        check_eq("t7_no_rd", rd_log.size() - rd_base, 0);
        check_eq("t7_no_wr", wr_log.size() - wr_base, 0);

        // Page $FF ends at $FFFF with no wrap.
        mark();
        start(8'hFF, 1'b1);
        cpu_rw_i = 1'b1;
        wait_done("t8_done");
        check_xfer("t8", 8'hFF);
        check_eq("t8_first_addr", rd_log[rd_base], 16'hFF00);
        check_eq("t8_last_addr", rd_log[rd_base + 255], 16'hFFFF);
        check_eq("t8_halt", halt_cnt - halt_base, 514);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
